// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : execute_muldiv
// Purpose  : Iterative RISC-V M-extension execute unit. One op in flight:
//            radix-2 shift-add multiply or restoring radix-2 divide, one bit
//            per cycle, followed by a sign-fixup cycle and a writeback cycle.
// Ports    : clk, Rst (sync, active-high), hold (pipeline freeze)
//            ID_EX_md_valid/op/rs1_fw/rs2_fw/rd : issue interface
//            md_busy                            : unit occupied, stall decode
//            EX_MEM_md_res/rd/regwrite          : registered writeback
// Revision : 1.0 - initial release
// ============================================================================
module execute_muldiv #(
  parameter int XLEN      = 32,
  parameter int REGADDR_W = 5,
  parameter int CNT_W     = $clog2(XLEN) + 1
) (
  input  logic                 clk,
  input  logic                 Rst,
  input  logic                 hold,
  input  logic                 ID_EX_md_valid,
  input  logic [2:0]           ID_EX_md_op,
  input  logic [XLEN-1:0]      ID_EX_rs1_fw,
  input  logic [XLEN-1:0]      ID_EX_rs2_fw,
  input  logic [REGADDR_W-1:0] ID_EX_rd,
  output logic                 md_busy,
  output logic [XLEN-1:0]      EX_MEM_md_res,
  output logic [REGADDR_W-1:0] EX_MEM_md_rd,
  output logic                 EX_MEM_md_regwrite
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [2:0]             r_op;
  logic [REGADDR_W-1:0]   r_rd;
  logic                   r_sa;
  logic                   r_sb;
  logic                   r_dz;
  logic                   r_ovf;
  logic [XLEN-1:0]        r_mag_a;
  logic [XLEN-1:0]        r_mag_b;
  // Multiply: {partial product high, multiplier shifting out low}.
  // Divide:   {partial remainder, dividend/quotient shifting left}.
  logic [2*XLEN-1:0]      r_prod;
  logic [CNT_W-1:0]       r_cnt;
  logic [XLEN-1:0]        r_result;
  logic                   r_busy;
  logic [XLEN-1:0]        r_res_out;
  logic [REGADDR_W-1:0]   r_rd_out;
  logic                   r_regwrite;

  // ---------------------------------------------------------------- decode
  logic            w_is_div;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_dz;
  logic            w_ovf;

  always_comb begin
    w_is_div = ID_EX_md_op[2];
    w_sa     = (ID_EX_md_op == 3'd1) || (ID_EX_md_op == 3'd2) ||
               (ID_EX_md_op == 3'd4) || (ID_EX_md_op == 3'd6);
    w_sb     = (ID_EX_md_op == 3'd1) || (ID_EX_md_op == 3'd4) ||
               (ID_EX_md_op == 3'd6);
    w_sa     = w_sa && ID_EX_rs1_fw[XLEN-1];
    w_sb     = w_sb && ID_EX_rs2_fw[XLEN-1];
    // Negating the most-negative value yields itself, which is exactly its
    // unsigned magnitude, so no special case is needed here.
    w_mag_a  = w_sa ? (~ID_EX_rs1_fw + 1'b1) : ID_EX_rs1_fw;
    w_mag_b  = w_sb ? (~ID_EX_rs2_fw + 1'b1) : ID_EX_rs2_fw;
    w_dz     = w_is_div && (ID_EX_rs2_fw == '0);
    w_ovf    = w_is_div && !ID_EX_md_op[0] &&
               (ID_EX_rs1_fw == {1'b1, {(XLEN-1){1'b0}}}) &&
               (ID_EX_rs2_fw == '1);
  end

  // ---------------------------------------------------------- iteration step
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_next;
  logic [XLEN:0]     w_shift;
  logic              w_ge;
  logic [XLEN-1:0]   w_rem_next;
  logic [2*XLEN-1:0] w_div_next;

  always_comb begin
    w_sum      = {1'b0, r_prod[2*XLEN-1:XLEN]} + {1'b0, r_mag_a};
    w_mul_next = r_prod[0] ? {w_sum, r_prod[XLEN-1:1]}
                           : {1'b0, r_prod[2*XLEN-1:1]};
    w_shift    = {r_prod[2*XLEN-1:XLEN], r_prod[XLEN-1]};
    w_ge       = (w_shift >= {1'b0, r_mag_b});
    // When the trial subtract succeeds the difference is below the divisor,
    // so the truncated XLEN-bit subtraction is exact.
    w_rem_next = w_ge ? (w_shift[XLEN-1:0] - r_mag_b) : w_shift[XLEN-1:0];
    w_div_next = {w_rem_next, r_prod[XLEN-2:0], w_ge};
  end

  // --------------------------------------------------------------- sign fix
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo_s;
  logic [XLEN-1:0]   w_rem_s;
  logic [XLEN-1:0]   w_a_raw;
  logic [XLEN-1:0]   w_fix_res;

  always_comb begin
    w_prod_s = (r_sa ^ r_sb) ? (~r_prod + 1'b1) : r_prod;
    w_quo_s  = (r_sa ^ r_sb) ? (~r_prod[XLEN-1:0] + 1'b1) : r_prod[XLEN-1:0];
    w_rem_s  = r_sa ? (~r_prod[2*XLEN-1:XLEN] + 1'b1) : r_prod[2*XLEN-1:XLEN];
    w_a_raw  = r_sa ? (~r_mag_a + 1'b1) : r_mag_a;
    case (r_op)
      3'd0:                w_fix_res = w_prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    w_fix_res = w_prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          w_fix_res = w_quo_s;
      default:             w_fix_res = w_rem_s;
    endcase
    if (r_dz) begin
      w_fix_res = r_op[1] ? w_a_raw : '1;
    end else if (r_ovf) begin
      // Overflow quotient equals the dividend, whose magnitude is itself.
      w_fix_res = r_op[1] ? '0 : r_mag_a;
    end
  end

  // -------------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (Rst) begin
      r_state    <= S_IDLE;
      r_op       <= '0;
      r_rd       <= '0;
      r_sa       <= 1'b0;
      r_sb       <= 1'b0;
      r_dz       <= 1'b0;
      r_ovf      <= 1'b0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_prod     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_busy     <= 1'b0;
      r_res_out  <= '0;
      r_rd_out   <= '0;
      r_regwrite <= 1'b0;
    end else if (hold) begin
      // Everything freezes; the writeback strobe is dropped so a pulse that
      // meets a freeze is never presented a second time.
      r_regwrite <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_regwrite <= 1'b0;
          if (ID_EX_md_valid) begin
            r_op    <= ID_EX_md_op;
            r_rd    <= ID_EX_rd;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_dz    <= w_dz;
            r_ovf   <= w_ovf;
            r_mag_a <= w_mag_a;
            r_mag_b <= w_mag_b;
            r_prod  <= {{XLEN{1'b0}}, (w_is_div ? w_mag_a : w_mag_b)};
            r_cnt   <= CNT_W'(XLEN);
            r_busy  <= 1'b1;
            r_state <= (w_dz || w_ovf) ? S_FIX : S_CALC;
          end
        end
        S_CALC: begin
          r_prod <= r_op[2] ? w_div_next : w_mul_next;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_result <= w_fix_res;
          r_state  <= S_DONE;
        end
        default: begin
          r_res_out  <= r_result;
          r_rd_out   <= r_rd;
          r_regwrite <= 1'b1;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign md_busy            = r_busy;
  assign EX_MEM_md_res      = r_res_out;
  assign EX_MEM_md_rd       = r_rd_out;
  assign EX_MEM_md_regwrite = r_regwrite;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_execute_muldiv
// Purpose  : Directed-vector self-checking bench for execute_muldiv (XLEN=32).
// Revision : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;

  logic        clk = 1'b0;
  logic        Rst;
  logic        hold;
  logic        valid;
  logic [2:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic [4:0]  rd;
  logic        busy;
  logic [31:0] res;
  logic [4:0]  res_rd;
  logic        regwrite;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  execute_muldiv #(.XLEN(32), .REGADDR_W(5)) dut (
    .clk               (clk),
    .Rst               (Rst),
    .hold              (hold),
    .ID_EX_md_valid    (valid),
    .ID_EX_md_op       (op),
    .ID_EX_rs1_fw      (rs1),
    .ID_EX_rs2_fw      (rs2),
    .ID_EX_rd          (rd),
    .md_busy           (busy),
    .EX_MEM_md_res     (res),
    .EX_MEM_md_rd      (res_rd),
    .EX_MEM_md_regwrite(regwrite)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op, optionally freeze the pipe (hold_len edges starting after
  // edge hold_at) and optionally try a second issue while busy (at intf_at).
  task automatic run_op(input string tag, input logic [2:0] i_op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] i_rd, input logic [31:0] exp,
                        input int exp_lat, input int hold_at, input int hold_len,
                        input int intf_at);
    int  cyc;
    bit  seen;
    @(negedge clk);
    valid = 1'b1; op = i_op; rs1 = a; rs2 = b; rd = i_rd;
    @(posedge clk);
    #1;
    valid = 1'b0;
    check({tag, "_busy"}, 64'(busy), 64'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (regwrite) begin
        seen = 1'b1;
      end else begin
        if (hold_len > 0 && cyc == hold_at) hold = 1'b1;
        if (hold_len > 0 && cyc == hold_at + hold_len) hold = 1'b0;
        if (cyc == intf_at) begin
          valid = 1'b1; op = 3'd0; rs1 = 32'd1; rs2 = 32'd1; rd = 5'd31;
        end else if (cyc == intf_at + 1) begin
          valid = 1'b0;
        end
      end
    end
    valid = 1'b0;
    hold  = 1'b0;
    check({tag, "_lat"}, seen ? 64'(cyc) : 64'hDEAD, 64'(exp_lat));
    check({tag, "_res"}, 64'(res), 64'(exp));
    check({tag, "_rd"}, 64'(res_rd), 64'(i_rd));
    check({tag, "_nobusy"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 64'(regwrite), 64'd0);
  endtask

  initial begin
    int wcount;
    Rst = 1'b1; hold = 1'b0; valid = 1'b0; op = '0; rs1 = '0; rs2 = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    Rst = 1'b0;
    check("rst_res", 64'(res), 64'd0);
    check("rst_rd", 64'(res_rd), 64'd0);
    check("rst_rw", 64'(regwrite), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);

    //      tag        op    a             b             rd     expected      lat hold  intf
    run_op("mulhu_ff", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1,  32'hFFFFFFFE, 34, 0, 0, -9);
    run_op("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2,        5'd2,  32'hFFFFFFFD, 34, 0, 0, -9);
    run_op("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2,        5'd3,  32'hFFFFFFFF, 34, 0, 0, -9);
    run_op("divu_dz",  3'd5, 32'd5,        32'd0,        5'd4,  32'hFFFFFFFF, 2,  0, 0, -9);
    run_op("remu_dz",  3'd7, 32'd5,        32'd0,        5'd5,  32'd5,        2,  0, 0, -9);
    run_op("div_ovf",  3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd6,  32'h80000000, 2,  0, 0, -9);
    run_op("rem_ovf",  3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd7,  32'd0,        2,  0, 0, -9);
    run_op("mul_hold", 3'd0, 32'd3,        32'hFFFFFFFC, 5'd8,  32'hFFFFFFF4, 39, 5, 5, -9);
    run_op("mulh_neg", 3'd1, 32'hFFFFFFFD, 32'd5,        5'd9,  32'hFFFFFFFF, 34, 0, 0, -9);
    run_op("mulhsu",   3'd2, 32'hFFFFFFFF, 32'd2,        5'd10, 32'hFFFFFFFF, 34, 0, 0, -9);
    run_op("mul_lo",   3'd0, 32'h12345678, 32'h10,       5'd11, 32'h23456780, 34, 0, 0, -9);
    run_op("mulhu_hi", 3'd3, 32'h80000000, 32'h4,        5'd12, 32'h2,        34, 0, 0, -9);
    run_op("div_nn",   3'd4, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd13, 32'd3,        34, 0, 0, -9);
    run_op("rem_nn",   3'd6, 32'hFFFFFFF9, 32'hFFFFFFFE, 5'd14, 32'hFFFFFFFF, 34, 0, 0, -9);
    run_op("div_dz_s", 3'd4, 32'hFFFFFFFB, 32'd0,        5'd15, 32'hFFFFFFFF, 2,  0, 0, -9);
    run_op("rem_dz_s", 3'd6, 32'hFFFFFFFB, 32'd0,        5'd16, 32'hFFFFFFFB, 2,  0, 0, -9);
    run_op("divu_ign", 3'd5, 32'd100,      32'd7,        5'd17, 32'd14,       34, 0, 0, 4);
    run_op("remu_rd0", 3'd7, 32'd100,      32'd7,        5'd0,  32'd2,        34, 0, 0, -9);

    // Reset in the middle of a divide, with a stray issue while busy.
    @(negedge clk);
    valid = 1'b1; op = 3'd5; rs1 = 32'd1000; rs2 = 32'd3; rd = 5'd20;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    valid = 1'b1; op = 3'd0; rd = 5'd21;
    @(posedge clk);
    #1;
    valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    Rst = 1'b1;
    @(posedge clk);
    #1;
    Rst = 1'b0;
    check("mid_rst_res", 64'(res), 64'd0);
    check("mid_rst_rd", 64'(res_rd), 64'd0);
    check("mid_rst_rw", 64'(regwrite), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    wcount = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (regwrite) wcount++;
    end
    check("mid_rst_nowb", 64'(wcount), 64'd0);
    run_op("post_rst", 3'd5, 32'd1000, 32'd3, 5'd22, 32'd333, 34, 0, 0, -9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
